ram_arbiter: RTL and testbench
==============================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter: TIMEOUT, default 16, max cycles a grant waits for ramstate==ACCESS before abort (range 2..255).
REQ-002 Ports (name  direction  width  meaning):
  CLK  in  1  clock, rising edge; nRST  in  1  reset, synchronous, active-low
  iREN  in  1  icache read request; iaddr  in  32  icache address
  iwait  out  1  low for exactly the cycle the icache read completes; iload  out  32  instruction data
  dREN  in  1  dcache read request; dWEN  in  1  dcache write request
  daddr  in  32  dcache address; dstore  in  32  dcache write data
  dwait  out  1  low for exactly the cycle the dcache access completes; dload  out  32  data-read data
  ramREN  out  1  RAM read enable; ramWEN  out  1  RAM write enable
  ramaddr  out  32  RAM address; ramstore  out  32  RAM write data; ramload  in  32  RAM read data
  ramstate  in  2  RAM status: 0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR
  err  out  1  one-cycle pulse on timeout or RAM ERROR abort

Function
REQ-003 Registered FSM states: IDLE, IGRANT, DGRANT; plus 8-bit timeout counter tcnt and 1-bit fairness flag last_d.
REQ-004 IDLE: no RAM enable asserted; ramaddr/ramstore = 0.
REQ-005 IDLE arbitration, next cycle: d-request only (dREN|dWEN) -> DGRANT; iREN only -> IGRANT; both -> IGRANT if last_d==1, else DGRANT; none -> stay IDLE.
REQ-006 IGRANT: ramREN=1, ramWEN=0, ramaddr=iaddr (combinational from inputs).
REQ-007 DGRANT: ramaddr=daddr, ramstore=dstore; dWEN=1 -> ramWEN=1, ramREN=0 (write wins if dREN also high); else ramREN=1, ramWEN=0.
REQ-008 ramREN and ramWEN never both 1.
REQ-009 Completion: in IGRANT with ramstate==ACCESS, iwait=0 that cycle; in DGRANT with ramstate==ACCESS, dwait=0 that cycle; next state IDLE.
REQ-010 iwait=1 and dwait=1 in every other cycle; ungranted requester always sees wait=1.
REQ-011 iload = ramload and dload = ramload (pass-through); valid only in cycle its wait is 0.
REQ-012 last_d set to 1 on DGRANT completion, cleared to 0 on IGRANT completion; unchanged on abort.
REQ-013 tcnt cleared on entry to a grant state, incremented each grant cycle without ACCESS; tcnt==TIMEOUT-1 without ACCESS -> IDLE next cycle, err=1 for the following one cycle.
REQ-014 ramstate==ERROR in grant state -> IDLE next cycle, err=1 for one cycle, wait stays 1 (requester retries).
REQ-015 Granted requester drops its enable before ACCESS -> IDLE next cycle, no wait pulse, no err.
REQ-016 ACCESS and timeout in same cycle: ACCESS wins (completion, no err).
REQ-017 Minimum transaction: grant cycle 1 after request; earliest completion same cycle as grant (zero-wait RAM); one IDLE cycle between back-to-back transactions.
REQ-018 Requests arriving while a grant is active are held off by wait=1; never dropped, never reordered beyond REQ-005.

Reset
REQ-019 nRST==0 at rising CLK: state=IDLE, tcnt=0, last_d=0, err=0; thus ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, iwait=1, dwait=1.
REQ-020 Reset mid-grant aborts the transaction immediately; no wait pulse, no err, regardless of ramstate.

Verification
REQ-021 iREN=1, iaddr=0x100, ramstate=ACCESS same cycle as IGRANT, ramload=0xDEADBEEF -> ramREN=1, ramaddr=0x100, iwait=0 one cycle, iload=0xDEADBEEF.
REQ-022 iREN=1 and dWEN=1 from reset, daddr=0x40, dstore=0x5, RAM 2 BUSY cycles then ACCESS -> DGRANT first, ramWEN=1, dwait low on 3rd grant cycle; IGRANT follows after one IDLE cycle.
REQ-023 Both requests held continuously -> grants alternate D, I, D, I; neither starves.
REQ-024 dREN=1, ramstate stuck BUSY, TIMEOUT=16 -> IDLE after 16 grant cycles, err pulses exactly once, dwait never 0, regrant follows.
REQ-025 ramstate=ERROR during IGRANT -> err pulse, iwait stays 1; nRST=0 mid-DGRANT -> all outputs at REQ-019 values next cycle.

Source files
------------

// File: rtl/ram_arbiter_if.sv
// Cache and RAM side signals of the RAM arbiter.
// slave is the arbiter view; master is the caches-plus-RAM view.
interface ram_arbiter_if;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;

  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dwait;
  logic [31:0] dload;

  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;

  logic        err;

  modport slave (
    input  iREN,
    input  iaddr,
    output iwait,
    output iload,
    input  dREN,
    input  dWEN,
    input  daddr,
    input  dstore,
    output dwait,
    output dload,
    output ramREN,
    output ramWEN,
    output ramaddr,
    output ramstore,
    input  ramload,
    input  ramstate,
    output err
  );

  modport master (
    output iREN,
    output iaddr,
    input  iwait,
    input  iload,
    output dREN,
    output dWEN,
    output daddr,
    output dstore,
    input  dwait,
    input  dload,
    input  ramREN,
    input  ramWEN,
    input  ramaddr,
    input  ramstore,
    output ramload,
    output ramstate,
    input  err
  );
endinterface

// File: rtl/ram_arbiter.sv
// Two-requester RAM arbiter: icache vs dcache with alternating
// fairness on contention, grant timeout and RAM error abort.
module ram_arbiter #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic          CLK,
  input  logic          nRST,
  ram_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    IGRANT,
    DGRANT
  } state_t;

  localparam logic [1:0] RS_ACCESS = 2'd2;
  localparam logic [1:0] RS_ERROR  = 2'd3;
  localparam logic [7:0] TLAST     = 8'(TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [7:0] tcnt_q, tcnt_d;
  logic       last_d_q, last_d_d;
  logic       err_q, err_d;

  logic d_req;
  logic gnt_en;
  logic hit;
  logic fault;
  logic expire;
  logic done;

  assign d_req  = bus.dREN | bus.dWEN;
  assign hit    = (bus.ramstate == RS_ACCESS);
  assign fault  = (bus.ramstate == RS_ERROR);
  assign expire = (tcnt_q == TLAST);

  always_comb begin
    gnt_en = 1'b0;
    case (state_q)
      IGRANT:  gnt_en = bus.iREN;
      DGRANT:  gnt_en = d_req;
      default: gnt_en = 1'b0;
    endcase
  end

  // A requester that drops out takes priority over any RAM status
  assign done = nRST & gnt_en & hit;

  always_comb begin
    state_d  = state_q;
    tcnt_d   = tcnt_q;
    last_d_d = last_d_q;
    err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        tcnt_d = '0;
        unique case (1'b1)
          d_req & bus.iREN:
            state_d = last_d_q ? IGRANT : DGRANT;
          d_req & ~bus.iREN:
            state_d = DGRANT;
          ~d_req & bus.iREN:
            state_d = IGRANT;
          default:
            state_d = IDLE;
        endcase
      end
      IGRANT, DGRANT: begin
        tcnt_d = tcnt_q + 8'd1;
        if (!gnt_en) begin
          state_d = IDLE;
        end else if (hit) begin
          state_d  = IDLE;
          last_d_d = (state_q == DGRANT);
        end else if (fault || expire) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = '0;
    bus.ramstore = '0;
    bus.iwait    = 1'b1;
    bus.dwait    = 1'b1;
    case (state_q)
      IGRANT: begin
        bus.ramREN  = 1'b1;
        bus.ramaddr = bus.iaddr;
        bus.iwait   = ~done;
      end
      DGRANT: begin
        bus.ramWEN   = bus.dWEN;
        bus.ramREN   = ~bus.dWEN;
        bus.ramaddr  = bus.daddr;
        bus.ramstore = bus.dstore;
        bus.dwait    = ~done;
      end
      default: ;
    endcase
  end

  assign bus.iload = bus.ramload;
  assign bus.dload = bus.ramload;
  assign bus.err   = err_q;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q  <= IDLE;
      tcnt_q   <= '0;
      last_d_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      tcnt_q   <= tcnt_d;
      last_d_q <= last_d_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Randomized scoreboard bench for ram_arbiter against a
// transaction-level model of owner, grant age and fairness.
module tb_ram_arbiter;

  localparam int TMO = 16;

  logic CLK = 1'b0;
  logic nRST;

  ram_arbiter_if bus();

  ram_arbiter #(.TIMEOUT(TMO)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  // kind: 0 icache done, 1 dcache done, 2 err pulse
  typedef struct {
    int          kind;
    int          stamp;
    logic [31:0] data;
  } ev_t;

  ev_t expq[$];

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  bit run_mon = 1'b0;

  logic        exp_ren, exp_wen;
  logic [31:0] exp_addr, exp_store;

  // model: owner 0 none, 1 icache, 2 dcache; age is 1 on first grant cycle
  int owner = 0;
  int age   = 0;
  bit lastd = 1'b0;

  bit i_act = 1'b0;
  bit d_act = 1'b0;
  int d_kind = 0;
  int mode = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic present(input int k, input logic [31:0] d);
    ev_t e;
    if (expq.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event: kind %0d at cycle %0d, none expected",
               k, cyc);
      return;
    end
    e = expq.pop_front();
    chk("event_kind", 32'(k), 32'(e.kind));
    chk("event_cycle", 32'(cyc), 32'(e.stamp));
    if (k != 2) chk("event_data", d, e.data);
  endtask

  always @(negedge CLK) begin
    if (run_mon) begin
      chk("ren_wen_excl", 32'(bus.ramREN & bus.ramWEN), 32'(0));
      chk("ramREN", 32'(bus.ramREN), 32'(exp_ren));
      chk("ramWEN", 32'(bus.ramWEN), 32'(exp_wen));
      chk("ramaddr", bus.ramaddr, exp_addr);
      chk("ramstore", bus.ramstore, exp_store);
      if (bus.iwait !== 1'b1) present(0, bus.iload);
      if (bus.dwait !== 1'b1) present(1, bus.dload);
      if (bus.err !== 1'b0) present(2, 32'd0);
    end
  end

  task automatic drive(input int m);
    int r;
    if (m == 2) begin
      i_act = 1'b0;
      d_act = 1'b0;
    end else begin
      if (!i_act && $urandom_range(0, 3) == 0) begin
        i_act = 1'b1;
        bus.iaddr = $urandom & 32'hffff_fffc;
      end else if (i_act && m == 0 && $urandom_range(0, 63) == 0) begin
        i_act = 1'b0;
      end
      if (!d_act && $urandom_range(0, 3) == 0) begin
        d_act = 1'b1;
        d_kind = int'($urandom_range(0, 2));
        bus.daddr = $urandom & 32'hffff_fffc;
        bus.dstore = $urandom;
      end else if (d_act && m == 0 && $urandom_range(0, 63) == 0) begin
        d_act = 1'b0;
      end
    end
    bus.iREN = i_act;
    bus.dREN = d_act && (d_kind != 1);
    bus.dWEN = d_act && (d_kind != 0);
    r = int'($urandom_range(0, 9));
    if (m == 1) bus.ramstate = 2'd1;
    else if (r < 4) bus.ramstate = 2'd2;
    else if (r < 8) bus.ramstate = 2'd1;
    else if (r == 8) bus.ramstate = 2'd0;
    else bus.ramstate = 2'd3;
    bus.ramload = $urandom;
    nRST = (m == 0 && $urandom_range(0, 149) == 0) ? 1'b0 : 1'b1;
  endtask

  task automatic model_step();
    bit dreq, en, live;
    int nxt;
    live = (nRST === 1'b1);
    dreq = bus.dREN | bus.dWEN;
    exp_ren = 1'b0;
    exp_wen = 1'b0;
    exp_addr = '0;
    exp_store = '0;
    nxt = owner;
    if (owner == 1) begin
      exp_ren = 1'b1;
      exp_addr = bus.iaddr;
    end else if (owner == 2) begin
      exp_wen = bus.dWEN;
      exp_ren = !bus.dWEN;
      exp_addr = bus.daddr;
      exp_store = bus.dstore;
    end
    if (owner == 0) begin
      age = 1;
      if (dreq && bus.iREN) nxt = lastd ? 1 : 2;
      else if (dreq) nxt = 2;
      else if (bus.iREN) nxt = 1;
    end else begin
      en = (owner == 1) ? bus.iREN : dreq;
      if (!en) begin
        nxt = 0;
      end else if (bus.ramstate == 2'd2) begin
        nxt = 0;
        if (live) begin
          lastd = (owner == 2);
          expq.push_back('{owner - 1, cyc, bus.ramload});
          if (owner == 1) i_act = 1'b0;
          else d_act = 1'b0;
        end
      end else if (bus.ramstate == 2'd3 || age == TMO) begin
        nxt = 0;
        if (live) expq.push_back('{2, cyc + 1, 32'd0});
      end else begin
        age++;
      end
    end
    if (!live) begin
      nxt = 0;
      lastd = 1'b0;
    end
    owner = nxt;
  endtask

  initial begin
    nRST = 1'b0;
    bus.iREN = 1'b0;
    bus.iaddr = '0;
    bus.dREN = 1'b0;
    bus.dWEN = 1'b0;
    bus.daddr = '0;
    bus.dstore = '0;
    bus.ramload = '0;
    bus.ramstate = 2'd0;
    exp_ren = 1'b0;
    exp_wen = 1'b0;
    exp_addr = '0;
    exp_store = '0;
    @(posedge CLK);
    for (int n = 1; n <= 2600; n++) begin
      cyc = n;
      #1;
      if (n <= 2000) mode = 0;
      else if (n <= 2080) mode = 1;
      else if (n <= 2560) mode = 0;
      else mode = 2;
      drive(mode);
      if (n <= 2) nRST = 1'b0;
      model_step();
      run_mon = 1'b1;
      if (n == 2) begin
        @(negedge CLK);
        #1;
        chk("rst_iwait", 32'(bus.iwait), 32'd1);
        chk("rst_dwait", 32'(bus.dwait), 32'd1);
        chk("rst_err", 32'(bus.err), 32'd0);
        chk("rst_ramREN", 32'(bus.ramREN), 32'd0);
        chk("rst_ramWEN", 32'(bus.ramWEN), 32'd0);
        chk("rst_ramaddr", bus.ramaddr, 32'd0);
        chk("rst_ramstore", bus.ramstore, 32'd0);
      end
      @(posedge CLK);
    end
    #1;
    run_mon = 1'b0;
    chk("queue_drained", 32'(expq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
